// File: rtl/arb_mux_n_pkg.sv
// Shared constants and helpers for the arb_mux_n registered selector.
package arb_mux_n_pkg;

   // Values of the mode input.
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Round-robin successor of a channel index: wraps from n-1 back to 0.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage : arb_mux_n_pkg

// File: rtl/arb_mux_n_rr_arbiter.sv
// Grant logic for arb_mux_n: fixed-select or rotating-priority search
// starting at ptr. Purely combinational; gnt is one-hot or all-zero.
module rr_arbiter
   import arb_mux_n_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int SELW     = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SELW-1:0]     ptr,
   input  logic                mode,
   input  logic [SELW-1:0]     sel,
   output logic [CHANNELS-1:0] gnt,
   output logic [SELW-1:0]     g
);

   // Pick the granted channel: sel when it is requesting (fixed mode), else
   // the first requester at or after ptr in circular order (round-robin).
   always_comb begin
      logic w_found;
      int   w_idx;
      gnt     = '0;
      g       = '0;
      w_found = 1'b0;
      w_idx   = 0;
      if (mode == MODE_FIXED) begin
         // An out-of-range sel matches no channel, so nothing is granted.
         for (int i = 0; i < CHANNELS; i++) begin
            if ((sel == SELW'(i)) && req[i]) begin
               gnt[i] = 1'b1;
               g      = SELW'(i);
            end
         end
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= CHANNELS) begin
               w_idx = w_idx - CHANNELS;
            end
            if (!w_found && req[w_idx]) begin
               w_found    = 1'b1;
               gnt[w_idx] = 1'b1;
               g          = SELW'(w_idx);
            end
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/arb_mux_n.sv
// N-channel, W-bit registered selector. One word per cycle moves from the
// granted input channel into a single output register, which holds it until
// the consumer takes it.
//
// Handshake: a word moves across an interface on a rising edge where valid
// and ready are both high. Valid never waits for ready; ready may depend
// combinationally on valid. Data is held stable while valid is high and the
// word has not been taken.
module arb_mux_n
   import arb_mux_n_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int SELW     = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mode,
   input  logic [SELW-1:0]           sel,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SELW-1:0]           out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   // Fewer than two channels leaves nothing to arbitrate.
   if (CHANNELS < 2) begin : g_param_check
      $error("arb_mux_n: CHANNELS must be at least 2");
   end

   logic                r_out_valid;
   logic [WIDTH-1:0]    r_out_data;
   logic [SELW-1:0]     r_out_chan;
   logic [SELW-1:0]     r_ptr;

   logic                w_load_en;
   logic [CHANNELS-1:0] w_gnt;
   logic [SELW-1:0]     w_g;
   logic                w_xfer;
   logic [WIDTH-1:0]    w_sel_data;
   logic [SELW-1:0]     w_ptr_next;

   rr_arbiter #(
      .CHANNELS (CHANNELS),
      .SELW     (SELW)
   ) u_arb (
      .req  (in_valid),
      .ptr  (r_ptr),
      .mode (mode),
      .sel  (sel),
      .gnt  (w_gnt),
      .g    (w_g)
   );

   // The output register can take a word when it is empty or being drained.
   assign w_load_en = !r_out_valid | out_ready;

   // Ready goes only to the granted channel, and never while in reset.
   assign in_ready  = (w_load_en && !rst) ? w_gnt : '0;

   // Grant only covers requesting channels, so any ready bit means a transfer.
   assign w_xfer    = |in_ready;

   assign w_ptr_next = SELW'(wrap_inc(int'(w_g), CHANNELS));

   // One-hot AND-OR of the channel words; at most one grant bit is set.
   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_sel_data = w_sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_gnt[i]}});
      end
   end

   // Output register: load on transfer, clear valid on a drain with no refill.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_chan  <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_sel_data;
         r_out_chan  <= w_g;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Rotating priority pointer: advances past the winner on round-robin
   // transfers only, so fixed-mode traffic leaves it where it was.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_xfer && (mode == MODE_RR)) begin
         r_ptr <= w_ptr_next;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_chan  = r_out_chan;

endmodule : arb_mux_n

// File: doc/arb_mux_n.md
# arb_mux_n

Parametrised N-channel, W-bit registered selector for the datapath's operand and write-back paths. It replaces fixed 4:1 combinational muxing wherever a source may stall. It accepts one word per cycle from a selected or round-robin-arbitrated channel over valid/ready handshakes. It holds the word in a single output register until the consumer takes it.

## Interface
- WIDTH, 32, data width per channel
- CHANNELS, 4, number of input channels (≥ 2)
- SELW, $clog2(CHANNELS), width of channel index
- clk  input  1  rising-edge clock (single domain)
- rst  input  1  reset; synchronous, active-high
- mode  input  1  0 = fixed select (MODE_FIXED), 1 = round-robin (MODE_RR)
- sel  input  SELW  channel index used in MODE_FIXED; ignored in MODE_RR
- in_data  input  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel word present
- in_ready  output  CHANNELS  per-channel accept; at most one bit high per cycle
- out_data  output  WIDTH  registered selected word
- out_chan  output  SELW  index of the channel that supplied out_data
- out_valid  output  1  out_data/out_chan hold a word
- out_ready  input  1  consumer accepts the word this cycle

## Operation
- load_en = !out_valid | out_ready. The output register is free or is being drained this cycle.
- Grant in MODE_FIXED: g = sel if in_valid[sel], else none. Other channels never granted, even if valid.
- Grant in MODE_RR: g = first i with in_valid[i], searching ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1 (modulo CHANNELS).
- in_ready[i] = load_en & (i == g). Purely combinational from inputs and state. Transfer on channel i when in_valid[i] & in_ready[i].
- On transfer: out_data ← word of g, out_chan ← g, out_valid ← 1.
- On drain (out_valid & out_ready) with no transfer: out_valid ← 0. out_data and out_chan keep their last values.
- Simultaneous drain and transfer: the new word replaces the old one and out_valid stays 1. Throughput is one word per cycle.
- ptr updates only on a transfer in MODE_RR: ptr ← (g == CHANNELS-1) ? 0 : g+1.
- ptr is untouched in MODE_FIXED. A later switch back to MODE_RR resumes from the retained ptr.
- Stall: while out_valid & !out_ready, out_data/out_chan/out_valid are stable and all in_ready are 0.
- sel ≥ CHANNELS (non-power-of-two CHANNELS) grants nothing. It is not an error.
- No grant with load_en high: out_valid ← 0 if draining, else unchanged.

## Timing
- Reset, at the rising edge with rst = 1: out_valid = 0, out_data = 0, out_chan = 0, ptr = 0. in_ready is 0 while rst is high.
- rst overrides any transfer or drain in the same cycle. A word held mid-stall is discarded.
- Latency: a word accepted at edge k appears on out_data with out_valid = 1 after edge k. One cycle.
- mode and sel are sampled combinationally each cycle. A change takes effect on that cycle's grant. No pipeline flush is needed.
- No combinational path from in_data to out_data.
- Combinational paths: out_ready → in_ready, and in_valid/sel/mode → in_ready.

## Structure
- Shared package/header: MODE_FIXED = 1'b0 and MODE_RR = 1'b1 constants. The CHANNELS ≥ 2 range check lives with the parameters.
- One sub-module, rr_arbiter. Parameter CHANNELS; inputs req[CHANNELS-1:0], ptr, mode, sel; outputs one-hot gnt and encoded g.
- The top level holds the output register, the ptr register, load_en logic and data selection, via a one-hot AND-OR over in_data.

## Test plan
- Reset with rst = 1 for 2 cycles while in_valid = 4'b1111 → out_valid = 0, out_data = 0, out_chan = 0, in_ready = 0 throughout.
- MODE_FIXED, sel = 2, channel 2 = 0xDEADBEEF, all valid, out_ready = 1 → in_ready = 4'b0100. Next cycle out_data = 0xDEADBEEF, out_chan = 2. Repeats every cycle.
- MODE_RR, all 4 valid, out_ready = 1 → out_chan sequence 0, 1, 2, 3, 0 on consecutive cycles. With only channels 1 and 3 valid → 1, 3, 1, 3.
- Stall: word 0x11 held, out_ready = 0 for 3 cycles with new input valid → out_data stays 0x11 and in_ready = 0. When out_ready = 1, new word loads the same cycle and out_valid stays 1.
- Mode switch: RR until ptr = 2, then FIXED with sel = 0 for 3 transfers, then back to RR with all valid → first RR grant is channel 2.
- rst asserted while out_valid = 1 and out_ready = 0 → after the edge out_valid = 0, ptr = 0. The first RR grant afterwards is channel 0.
